mem_arbiter: RTL and testbench

- Two-master arbiter for the single-port 32-bit system RAM.
- Master 0 is the cpu core's memory port; master 1 is an auxiliary requester (UART program loader or DMA).
- Grants one transaction at a time, registers the winning request, and steers the RAM's read data back to the owner.
- Default policy: fixed priority to master 0, with a starvation guard for master 1.

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of the single-port 32-bit system RAM.
// Define MEM_ARBITER_RR_EN for strict round-robin instead of priority + starvation guard.
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_rd_en,
    input  logic              m0_wr_en,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wr_data,
    input  logic [3:0]        m0_wr_mask,
    output logic [31:0]       m0_rd_data,
    output logic              m0_rd_valid,
    output logic              m0_wr_ack,
    input  logic              m1_rd_en,
    input  logic              m1_wr_en,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wr_data,
    input  logic [3:0]        m1_wr_mask,
    output logic [31:0]       m1_rd_data,
    output logic              m1_rd_valid,
    output logic              m1_wr_ack,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    output logic [3:0]        mem_wr_mask,
    input  logic [31:0]       mem_rd_data,
    output logic              busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wr_data;
    logic [3:0]        r_wr_mask;

    logic w_m0_pend;
    logic w_m1_pend;
    logic w_any;
    logic w_grant1;
    logic w_idle;
    logic w_access;
    logic w_resp;

    assign w_m0_pend = m0_rd_en | m0_wr_en;
    assign w_m1_pend = m1_rd_en | m1_wr_en;
    assign w_any     = w_m0_pend | w_m1_pend;
    assign w_idle    = (r_state == S_IDLE);
    assign w_access  = (r_state == S_ACCESS);
    assign w_resp    = (r_state == S_RESP);

`ifdef MEM_ARBITER_RR_EN
    logic r_last;

    // Contention goes to whoever did not win the previous grant.
    assign w_grant1 = w_m1_pend & (~w_m0_pend | ~r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_idle && w_any) begin
            r_last <= w_grant1;
        end
    end
`else
    localparam int CNT_W = $clog2(MAX_WAIT + 2);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_wait_cnt;

    assign w_grant1 = w_m1_pend &
                      (~w_m0_pend | (r_wait_cnt == MAX_CNT));

    // Counts master 1 losses in IDLE; saturates so the force stays armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_idle && w_any) begin
            if (w_grant1) begin
                r_wait_cnt <= '0;
            end else if (w_m1_pend && (r_wait_cnt != MAX_CNT)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_owner   <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_wr_mask <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_ACCESS;
                        r_owner <= w_grant1;
                        if (w_grant1) begin
                            r_wr      <= m1_wr_en;
                            r_addr    <= m1_addr;
                            r_wr_data <= m1_wr_data;
                            r_wr_mask <= m1_wr_mask;
                        end else begin
                            r_wr      <= m0_wr_en;
                            r_addr    <= m0_addr;
                            r_wr_data <= m0_wr_data;
                            r_wr_mask <= m0_wr_mask;
                        end
                    end
                end
                S_ACCESS: begin
                    r_state <= r_wr ? S_IDLE : S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Writes to address 0 are acknowledged but never reach the RAM.
    assign mem_rd_en   = w_access & ~r_wr;
    assign mem_wr_en   = w_access & r_wr & (r_addr != '0);
    assign mem_addr    = w_access ? r_addr : '0;
    assign mem_wr_data = w_access ? r_wr_data : '0;
    assign mem_wr_mask = w_access ? r_wr_mask : 4'b1111;

    assign m0_wr_ack   = w_access & r_wr & ~r_owner;
    assign m1_wr_ack   = w_access & r_wr & r_owner;
    assign m0_rd_valid = w_resp & ~r_owner;
    assign m1_rd_valid = w_resp & r_owner;
    assign m0_rd_data  = m0_rd_valid ? mem_rd_data : '0;
    assign m1_rd_data  = m1_rd_valid ? mem_rd_data : '0;

    assign busy = ~w_idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, hand-written reset/starvation
// sequences and a randomized run against a transaction-level model.
module tb_mem_arbiter;

    localparam int MAX_WAIT = 8;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } req_t;

    typedef struct {
        req_t        r0;
        req_t        r1;
        logic [31:0] rdat;
        logic [2:0]  strb;   // {busy, mem_rd_en, mem_wr_en}
        logic [1:0]  chk;    // {check addr, check wdata+mask}
        logic [15:0] ea;
        logic [31:0] ed;
        logic [3:0]  em;
        logic [3:0]  hs;     // {m0 valid, m0 ack, m1 valid, m1 ack}
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;

    localparam req_t NONE = '{1'b0, 1'b0, 16'h0, 32'h0, 4'h0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    req_t        rq [2];
    logic [31:0] m0_rd_data, m1_rd_data;
    logic        m0_rd_valid, m0_wr_ack, m1_rd_valid, m1_wr_ack;
    logic        mem_rd_en, mem_wr_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_mask;
    logic [31:0] mem_rd_data;
    logic        busy;

    int          n_err = 0;
    int          n_chk = 0;
    logic        use_ram = 1'b0;
    logic [31:0] tbl_rd = 32'h0;
    logic [31:0] ram_q = 32'h0;
    bit   [31:0] ram    [0:65535];
    bit          ram_ok [0:65535];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .MAX_WAIT(MAX_WAIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0_rd_en    (rq[0].rd),
        .m0_wr_en    (rq[0].wr),
        .m0_addr     (rq[0].a),
        .m0_wr_data  (rq[0].d),
        .m0_wr_mask  (rq[0].m),
        .m0_rd_data  (m0_rd_data),
        .m0_rd_valid (m0_rd_valid),
        .m0_wr_ack   (m0_wr_ack),
        .m1_rd_en    (rq[1].rd),
        .m1_wr_en    (rq[1].wr),
        .m1_addr     (rq[1].a),
        .m1_wr_data  (rq[1].d),
        .m1_wr_mask  (rq[1].m),
        .m1_rd_data  (m1_rd_data),
        .m1_rd_valid (m1_rd_valid),
        .m1_wr_ack   (m1_wr_ack),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_mask (mem_wr_mask),
        .mem_rd_data (mem_rd_data),
        .busy        (busy)
    );

    function automatic logic [31:0] init_val(input logic [15:0] a);
        return {~a, a} ^ 32'hA5C3_0F1E;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0]  m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Simple synchronous RAM: read data valid the cycle after mem_rd_en.
    always @(posedge clk) begin
        if (mem_wr_en) begin
            ram[mem_addr] <= merge(ram_ok[mem_addr] ? ram[mem_addr]
                                   : init_val(mem_addr),
                                   mem_wr_data, mem_wr_mask);
            ram_ok[mem_addr] <= 1'b1;
        end
        if (mem_rd_en)
            ram_q <= ram_ok[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
    end

    assign mem_rd_data = use_ram ? ram_q : tbl_rd;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input req_t r0, input req_t r1,
                                input logic [31:0] rdat,
                                input logic [2:0] strb,
                                input logic [1:0] c,
                                input logic [15:0] ea,
                                input logic [31:0] ed,
                                input logic [3:0] em,
                                input logic [3:0] hs,
                                input logic [31:0] d0,
                                input logic [31:0] d1);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.rdat = rdat; v.strb = strb; v.chk = c;
        v.ea = ea; v.ed = ed; v.em = em; v.hs = hs; v.d0 = d0; v.d1 = d1;
        return v;
    endfunction

    // Transaction-level model state for the random phase.
    logic [31:0] mm [int];
    int          g_cyc, idle_from, losses;
    logic        last, g_own, g_wr;
    logic [15:0] g_a;
    logic [31:0] g_d;
    logic [3:0]  g_m;
    logic [15:0] addrs [8];

    function automatic logic [31:0] mval(input logic [15:0] a);
        return mm.exists(int'(a)) ? mm[int'(a)] : init_val(a);
    endfunction

    function automatic req_t new_req();
        req_t r;
        int   k;
        k = $urandom_range(2, 0);
        r.rd = (k != 1);
        r.wr = (k != 0);
        r.a  = addrs[$urandom_range(7, 0)];
        r.d  = $urandom;
        r.m  = 4'($urandom_range(15, 0));
        return r;
    endfunction

    vec_t tbl [12];

    initial begin
        req_t rd100, wr0, wr200, both0, both1;
        int   grants [$];
        rd100 = '{1'b1, 1'b0, 16'h0100, 32'h0, 4'h0};
        wr0   = '{1'b0, 1'b1, 16'h0000, 32'hAAAA_5555, 4'hF};
        wr200 = '{1'b0, 1'b1, 16'h0200, 32'h1234_5678, 4'b1100};
        both0 = '{1'b1, 1'b1, 16'h0300, 32'h1111_1111, 4'b0011};
        both1 = '{1'b1, 1'b1, 16'h0304, 32'h2222_2222, 4'b1111};
        tbl[0]  = mk(rd100, NONE, 0, 3'b000, 2'b00, 0, 0, 0, 4'b0000, 0, 0);
        tbl[1]  = mk(rd100, NONE, 0, 3'b110, 2'b10, 16'h0100, 0, 0,
                     4'b0000, 0, 0);
        tbl[2]  = mk(rd100, NONE, 32'hDEADBEEF, 3'b100, 2'b00, 0, 0, 0,
                     4'b1000, 32'hDEADBEEF, 0);
        tbl[3]  = mk(wr0, NONE, 32'hDEADBEEF, 3'b000, 2'b00, 0, 0, 0,
                     4'b0000, 0, 0);
        tbl[4]  = mk(wr0, NONE, 32'hDEADBEEF, 3'b100, 2'b00, 0, 0, 0,
                     4'b0100, 0, 0);
        tbl[5]  = mk(NONE, wr200, 0, 3'b000, 2'b00, 0, 0, 0, 4'b0000, 0, 0);
        tbl[6]  = mk(NONE, wr200, 0, 3'b101, 2'b11, 16'h0200, 32'h12345678,
                     4'b1100, 4'b0001, 0, 0);
        tbl[7]  = mk(both0, both1, 0, 3'b000, 2'b00, 0, 0, 0, 4'b0000, 0, 0);
        tbl[8]  = mk(both0, both1, 0, 3'b101, 2'b11, 16'h0300, 32'h11111111,
                     4'b0011, 4'b0100, 0, 0);
        tbl[9]  = mk(NONE, both1, 0, 3'b000, 2'b00, 0, 0, 0, 4'b0000, 0, 0);
        tbl[10] = mk(NONE, both1, 0, 3'b101, 2'b11, 16'h0304, 32'h22222222,
                     4'b1111, 4'b0001, 0, 0);
        tbl[11] = mk(NONE, NONE, 0, 3'b000, 2'b00, 0, 0, 0, 4'b0000, 0, 0);
        addrs = '{16'h0000, 16'h0004, 16'h0008, 16'h0100,
                  16'h0102, 16'h0203, 16'h7FFC, 16'hFFFF};
        rq[0] = NONE;
        rq[1] = NONE;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst strobes", 32'({busy, mem_rd_en, mem_wr_en}), 0);
        chk("rst hs", 32'({m0_rd_valid, m0_wr_ack, m1_rd_valid, m1_wr_ack}), 0);
        chk("rst rdata", m0_rd_data | m1_rd_data, 0);
        chk("rst bus", 32'(mem_addr) | mem_wr_data, 0);
        chk("rst mask", 32'(mem_wr_mask), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            rq[0] = tbl[i].r0;
            rq[1] = tbl[i].r1;
            tbl_rd = tbl[i].rdat;
            #1;
            chk($sformatf("v%0d strobes", i),
                32'({busy, mem_rd_en, mem_wr_en}), 32'(tbl[i].strb));
            chk($sformatf("v%0d hs", i),
                32'({m0_rd_valid, m0_wr_ack, m1_rd_valid, m1_wr_ack}),
                32'(tbl[i].hs));
            chk($sformatf("v%0d m0_rd_data", i), m0_rd_data, tbl[i].d0);
            chk($sformatf("v%0d m1_rd_data", i), m1_rd_data, tbl[i].d1);
            if (tbl[i].chk[1])
                chk($sformatf("v%0d mem_addr", i), 32'(mem_addr),
                    32'(tbl[i].ea));
            if (tbl[i].chk[0]) begin
                chk($sformatf("v%0d mem_wr_data", i), mem_wr_data, tbl[i].ed);
                chk($sformatf("v%0d mem_wr_mask", i), 32'(mem_wr_mask),
                    32'(tbl[i].em));
            end
            @(negedge clk);
        end

        // Reset asserted during RESP of a master 1 read
        rq[1] = '{1'b1, 1'b0, 16'h0040, 32'h0, 4'h0};
        tbl_rd = 32'hCAFE_F00D;
        #1;
        chk("rstresp idle busy", 32'(busy), 0);
        @(negedge clk);
        #1;
        chk("rstresp access", 32'({mem_rd_en, mem_addr}), 32'h1_0040);
        @(negedge clk);
        #1;
        chk("rstresp valid", 32'(m1_rd_valid), 1);
        chk("rstresp data", m1_rd_data, 32'hCAFE_F00D);
        rst_n = 1'b0;
        rq[1] = NONE;
        #1;
        chk("rstresp async valid", 32'(m1_rd_valid), 0);
        chk("rstresp async data", m1_rd_data, 0);
        chk("rstresp async busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rstresp after %0d", i),
                32'({busy, m1_rd_valid, m1_wr_ack}), 0);
            @(negedge clk);
        end

        // Starvation: both masters continuously pending writes
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rq[0] = '{1'b0, 1'b1, 16'h0400, 32'h0000_0A0A, 4'hF};
        rq[1] = '{1'b0, 1'b1, 16'h0404, 32'h0000_0B0B, 4'hF};
        for (int cyc = 0; cyc < 100 && grants.size() < 18; cyc++) begin
            @(negedge clk);
            #1;
            if (m0_wr_ack) grants.push_back(0);
            if (m1_wr_ack) grants.push_back(1);
        end
        chk("starve grant count", 32'(grants.size()), 18);
        for (int k = 0; k < grants.size() && k < 18; k++) begin
`ifdef MEM_ARBITER_RR_EN
            chk($sformatf("rr grant %0d", k), 32'(grants[k]), 32'(k % 2));
`else
            chk($sformatf("starve grant %0d", k), 32'(grants[k]),
                32'((k % 9) == 8));
`endif
        end

        // Randomized run against the transaction model
        rq[0] = NONE;
        rq[1] = NONE;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        use_ram = 1'b1;
        g_cyc = -10; g_wr = 1'b1; g_own = 1'b0; idle_from = 0;
        losses = 0; last = 1'b1; g_a = 0; g_d = 0; g_m = 0;
        for (int c = 0; c < 3000; c++) begin
            logic acc, resp, p0, p1, w;
            #1;
            acc  = (c == g_cyc + 1);
            resp = !g_wr && (c == g_cyc + 2);
            chk("rnd busy", 32'(busy), 32'(acc || resp));
            chk("rnd mem_rd_en", 32'(mem_rd_en), 32'(acc && !g_wr));
            chk("rnd mem_wr_en", 32'(mem_wr_en),
                32'(acc && g_wr && (g_a != 0)));
            chk("rnd m0 hs", 32'({m0_rd_valid, m0_wr_ack}),
                32'({resp && !g_own, acc && g_wr && !g_own}));
            chk("rnd m1 hs", 32'({m1_rd_valid, m1_wr_ack}),
                32'({resp && g_own, acc && g_wr && g_own}));
            chk("rnd m0_rd_data", m0_rd_data,
                (resp && !g_own) ? mval(g_a) : 0);
            chk("rnd m1_rd_data", m1_rd_data,
                (resp && g_own) ? mval(g_a) : 0);
            if (acc) begin
                chk("rnd mem_addr", 32'(mem_addr), 32'(g_a));
                if (g_wr) begin
                    chk("rnd mem_wr_data", mem_wr_data, g_d);
                    chk("rnd mem_wr_mask", 32'(mem_wr_mask), 32'(g_m));
                    if (g_a != 0) mm[int'(g_a)] = merge(mval(g_a), g_d, g_m);
                end
            end
            if (m0_wr_ack || m0_rd_valid)
                rq[0] = ($urandom_range(1, 0) != 0) ? new_req() : NONE;
            else if (!(rq[0].rd || rq[0].wr) && $urandom_range(2, 0) == 0)
                rq[0] = new_req();
            if (m1_wr_ack || m1_rd_valid)
                rq[1] = ($urandom_range(1, 0) != 0) ? new_req() : NONE;
            else if (!(rq[1].rd || rq[1].wr) && $urandom_range(2, 0) == 0)
                rq[1] = new_req();
            p0 = rq[0].rd || rq[0].wr;
            p1 = rq[1].rd || rq[1].wr;
            if (c >= idle_from && (p0 || p1)) begin
`ifdef MEM_ARBITER_RR_EN
                w = p1 && (!p0 || !last);
                last = w;
`else
                w = p1 && (!p0 || losses == MAX_WAIT);
                if (w) losses = 0;
                else if (p1 && losses < MAX_WAIT) losses++;
`endif
                g_cyc = c;
                g_own = w;
                g_wr  = rq[int'(w)].wr;
                g_a   = rq[int'(w)].a;
                g_d   = rq[int'(w)].d;
                g_m   = rq[int'(w)].m;
                idle_from = c + (g_wr ? 2 : 3);
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
